// File: rtl/hazard_detect_pkg.sv
// ---------------------------------------------------------------------------
// hazard_detect_pkg
// Shared definitions for the ID-stage hazard detector and the EX-stage
// forwarding mux: register/opcode widths, RV32I major opcodes, hazard codes,
// the detector FSM state type and small opcode-class helpers.
// No ports (package).
// ---------------------------------------------------------------------------
package hazard_detect_pkg;

  localparam int XLEN_REGS = 5;
  localparam int OP_W      = 7;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_OP     = 7'b0110011;
  localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

  // Codes consumed by the forwarding mux; EX-sourced codes travel on
  // hazard_reg1, MEM-sourced codes on hazard_reg2.
  localparam logic [2:0] HZ_NONE    = 3'd0;
  localparam logic [2:0] HZ_EX_RS1  = 3'd1;
  localparam logic [2:0] HZ_EX_RS2  = 3'd2;
  localparam logic [2:0] HZ_MEM_RS1 = 3'd3;
  localparam logic [2:0] HZ_MEM_RS2 = 3'd4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } hd_state_t;

  // Stores and branches carry no destination; x0 is never a real write.
  function automatic logic is_writer(input logic [OP_W-1:0] op,
                                     input logic [XLEN_REGS-1:0] rd);
    return (op != OP_STORE) && (op != OP_BRANCH) && (rd != '0);
  endfunction

  function automatic logic reads_rs1(input logic [OP_W-1:0] op);
    return (op != OP_LUI) && (op != OP_AUIPC) && (op != OP_JAL);
  endfunction

  function automatic logic reads_rs2(input logic [OP_W-1:0] op);
    return (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/hazard_detect_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Shadow copy of the destination registers held by the EX and MEM stages,
// plus the match logic against the sources of the instruction in ID.
// Ports:
//   clk, rst_n            clock / async active-low reset
//   id_valid, id_op       ID instruction qualifier and opcode
//   id_rs1, id_rs2, id_rd ID register indices
//   advance               ID instruction really moves into EX this edge
//   rs1_ex, rs2_ex        source matches the EX destination
//   rs1_mem, rs2_mem      source matches the MEM destination (EX not matching)
//   ex_ld                 the EX-stage instruction is a load
// ---------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_detect_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [OP_W-1:0]      id_op,
  input  logic [XLEN_REGS-1:0] id_rs1,
  input  logic [XLEN_REGS-1:0] id_rs2,
  input  logic [XLEN_REGS-1:0] id_rd,
  input  logic                 advance,
  output logic                 rs1_ex,
  output logic                 rs2_ex,
  output logic                 rs1_mem,
  output logic                 rs2_mem,
  output logic                 ex_ld
);

  logic                 ex_v;
  logic                 mem_v;
  logic [XLEN_REGS-1:0] ex_rd;
  logic [XLEN_REGS-1:0] mem_rd;
  logic                 use_rs1;
  logic                 use_rs2;

  // x0 sources are excluded here so index 0 can never produce a match.
  assign use_rs1 = id_valid && reads_rs1(id_op) && (id_rs1 != '0);
  assign use_rs2 = id_valid && reads_rs2(id_op) && (id_rs2 != '0);

  // The younger producer (EX) shadows an older MEM write of the same index.
  assign rs1_ex  = use_rs1 && ex_v && (id_rs1 == ex_rd);
  assign rs2_ex  = use_rs2 && ex_v && (id_rs2 == ex_rd);
  assign rs1_mem = use_rs1 && mem_v && (id_rs1 == mem_rd) && !rs1_ex;
  assign rs2_mem = use_rs2 && mem_v && (id_rs2 == mem_rd) && !rs2_ex;

  // A stalled or flushed ID slot enters EX as a bubble with no destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v   <= 1'b0;
      ex_rd  <= '0;
      ex_ld  <= 1'b0;
      mem_v  <= 1'b0;
      mem_rd <= '0;
    end else begin
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      ex_v   <= advance && is_writer(id_op, id_rd);
      ex_rd  <= advance ? id_rd : '0;
      ex_ld  <= advance && (id_op == OP_LOAD);
    end
  end

endmodule

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// ID-stage hazard detector. Produces registered forwarding codes for the
// EX-stage mux, a combinational IF/ID stall and a registered bubble flag.
// Optional build macro HAZARD_STATS_EN adds saturating stall/forward counters.
// Ports:
//   clk, rst_n               clock / async active-low reset
//   id_valid                 ID holds a real instruction
//   id_op, id_rs1/2, id_rd   ID opcode and register indices
//   flush                    redirect: kill ID instruction and pending HOLD
//   is_hazard1, hazard_reg1  EX-sourced forward (codes 1/2)
//   is_hazard2, hazard_reg2  MEM-sourced forward (codes 3/4)
//   stall                    hold PC and IF/ID this cycle
//   bubble                   EX holds an injected NOP this cycle
//   stall_cycles, forward_count  (HAZARD_STATS_EN only) event counters
// ---------------------------------------------------------------------------
module hazard_detect
  import hazard_detect_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [OP_W-1:0]      id_op,
  input  logic [XLEN_REGS-1:0] id_rs1,
  input  logic [XLEN_REGS-1:0] id_rs2,
  input  logic [XLEN_REGS-1:0] id_rd,
  input  logic                 flush,
  output logic                 is_hazard1,
  output logic                 is_hazard2,
  output logic [2:0]           hazard_reg1,
  output logic [2:0]           hazard_reg2,
  output logic                 stall,
  output logic                 bubble
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          forward_count
`endif
);

  hd_state_t  state;
  logic [1:0] cnt;

  logic rs1_ex;
  logic rs2_ex;
  logic rs1_mem;
  logic rs2_mem;
  logic ex_ld;
  logic advance;

  logic       load_use;
  logic       dual_ex;
  logic       dual_mem;
  logic       blocking;
  logic       stall_raw;
  logic [2:0] code_ex;
  logic [2:0] code_mem;

  hazard_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .id_valid (id_valid),
    .id_op    (id_op),
    .id_rs1   (id_rs1),
    .id_rs2   (id_rs2),
    .id_rd    (id_rd),
    .advance  (advance),
    .rs1_ex   (rs1_ex),
    .rs2_ex   (rs2_ex),
    .rs1_mem  (rs1_mem),
    .rs2_mem  (rs2_mem),
    .ex_ld    (ex_ld)
  );

  // Both operands hitting one stage means rs1 == rs2; only one code can be
  // issued per stage, so the instruction waits for the register-file write.
  always_comb begin
    load_use  = ex_ld && (rs1_ex || rs2_ex);
    dual_ex   = rs1_ex && rs2_ex;
    dual_mem  = rs1_mem && rs2_mem;
    blocking  = load_use || dual_ex || dual_mem;
    code_ex   = rs1_ex  ? HZ_EX_RS1  : (rs2_ex  ? HZ_EX_RS2  : HZ_NONE);
    code_mem  = rs1_mem ? HZ_MEM_RS1 : (rs2_mem ? HZ_MEM_RS2 : HZ_NONE);
    stall_raw = (state == ST_HOLD) ? ((cnt != 2'd0) || blocking) : blocking;
  end

  // A redirect must always win so the new PC can load.
  assign stall   = stall_raw && !flush;
  assign advance = id_valid && !flush && !stall;

  // FSM plus registered outputs; codes are captured on the edge that moves
  // the ID instruction into EX, otherwise EX sees a cleared slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      cnt         <= 2'd0;
      hazard_reg1 <= HZ_NONE;
      hazard_reg2 <= HZ_NONE;
      is_hazard1  <= 1'b0;
      is_hazard2  <= 1'b0;
      bubble      <= 1'b0;
    end else begin
      hazard_reg1 <= advance ? code_ex  : HZ_NONE;
      hazard_reg2 <= advance ? code_mem : HZ_NONE;
      is_hazard1  <= advance && (code_ex  != HZ_NONE);
      is_hazard2  <= advance && (code_mem != HZ_NONE);
      bubble      <= stall;
      if (flush) begin
        state <= ST_RUN;
        cnt   <= 2'd0;
      end else begin
        case (state)
          ST_RUN: begin
            if (stall_raw) begin
              state <= ST_HOLD;
              // An EX producer needs one extra cycle to pass through MEM.
              cnt   <= (dual_ex && !load_use) ? 2'd1 : 2'd0;
            end
          end
          ST_HOLD: begin
            if (stall_raw) begin
              if (cnt != 2'd0) cnt <= cnt - 2'd1;
            end else begin
              state <= ST_RUN;
            end
          end
          default: begin
            state <= ST_RUN;
            cnt   <= 2'd0;
          end
        endcase
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] fwd_inc;

  always_comb begin
    fwd_inc = {31'd0, advance && (code_ex != HZ_NONE)}
            + {31'd0, advance && (code_mem != HZ_NONE)};
  end

  // Saturating event counters: one per stall cycle, one per issued code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles  <= 32'd0;
      forward_count <= 32'd0;
    end else begin
      if (stall && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (forward_count > (32'hFFFF_FFFF - fwd_inc))
        forward_count <= 32'hFFFF_FFFF;
      else
        forward_count <= forward_count + fwd_inc;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_detect.sv
// ---------------------------------------------------------------------------
// tb_hazard_detect
// Scoreboard bench for hazard_detect. A driver issues directed and random
// instruction streams, a behavioural pipeline model predicts stall/codes and
// queues them; an independent monitor pops and compares every cycle.
// Also exercises async reset in the middle of a HOLD. With HAZARD_STATS_EN
// defined the statistic counters are compared against the model totals.
// ---------------------------------------------------------------------------
module tb_hazard_detect;

  localparam bit [6:0] LOAD   = 7'b0000011;
  localparam bit [6:0] STORE  = 7'b0100011;
  localparam bit [6:0] BRANCH = 7'b1100011;
  localparam bit [6:0] JAL    = 7'b1101111;
  localparam bit [6:0] JALR   = 7'b1100111;
  localparam bit [6:0] OPR    = 7'b0110011;
  localparam bit [6:0] OPI    = 7'b0010011;
  localparam bit [6:0] LUI    = 7'b0110111;
  localparam bit [6:0] AUIPC  = 7'b0010111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [6:0] id_op = '0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic [4:0] id_rd = '0;
  logic       flush = 1'b0;
  logic       is_hazard1;
  logic       is_hazard2;
  logic [2:0] hazard_reg1;
  logic [2:0] hazard_reg2;
  logic       stall;
  logic       bubble;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] forward_count;
`endif

  hazard_detect dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_op       (id_op),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .flush       (flush),
    .is_hazard1  (is_hazard1),
    .is_hazard2  (is_hazard2),
    .hazard_reg1 (hazard_reg1),
    .hazard_reg2 (hazard_reg2),
    .stall       (stall),
    .bubble      (bubble)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles  (stall_cycles),
    .forward_count (forward_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       stall;
    bit [2:0] h1;
    bit [2:0] h2;
    bit       bub;
  } exp_t;

  // One in-flight instruction as seen by a later reader.
  typedef struct {
    bit       writes;
    bit [4:0] rd;
    bit       is_load;
  } slot_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    cycle = 0;
  bit    mon_en = 1'b0;

  slot_t ex_slot;
  slot_t mem_slot;
  bit    holding;
  int    hold_left;
  int    model_stalls = 0;
  int    model_fwds = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s cycle=%0d got=%0d exp=%0d", name, cycle, actual, expected);
  endtask

  function automatic bit writes_reg(input bit [6:0] op, input bit [4:0] rd);
    if (rd == 5'd0) return 1'b0;
    return !(op == STORE || op == BRANCH);
  endfunction

  function automatic bit uses_rs1(input bit [6:0] op);
    return !(op == LUI || op == AUIPC || op == JAL);
  endfunction

  function automatic bit uses_rs2(input bit [6:0] op);
    return (op == OPR || op == STORE || op == BRANCH);
  endfunction

  // Which stage (1 = EX, 2 = MEM, 0 = none) will supply register r.
  function automatic int producer_stage(input bit [4:0] r);
    if (r == 5'd0) return 0;
    if (ex_slot.writes && ex_slot.rd == r) return 1;
    if (mem_slot.writes && mem_slot.rd == r) return 2;
    return 0;
  endfunction

  // Behavioural pipeline: predicts this cycle's stall and the outputs
  // registered at the coming edge, then shifts the pipeline.
  task automatic model_step(input bit v, input bit [6:0] op, input bit [4:0] r1,
                            input bit [4:0] r2, input bit [4:0] rd, input bit fl,
                            output exp_t e);
    int s1;
    int s2;
    bit load_use;
    bit same_stage;
    bit raw;
    bit adv;
    s1 = (v && uses_rs1(op)) ? producer_stage(r1) : 0;
    s2 = (v && uses_rs2(op)) ? producer_stage(r2) : 0;
    load_use   = ex_slot.is_load && (s1 == 1 || s2 == 1);
    same_stage = (s1 != 0) && (s1 == s2);
    raw = load_use || same_stage || (holding && hold_left > 0);
    e.stall = raw && !fl;
    adv = v && !fl && !e.stall;
    e.h1 = !adv ? 3'd0 : (s1 == 1) ? 3'd1 : (s2 == 1) ? 3'd2 : 3'd0;
    e.h2 = !adv ? 3'd0 : (s1 == 2) ? 3'd3 : (s2 == 2) ? 3'd4 : 3'd0;
    e.bub = e.stall;
    if (e.stall) model_stalls++;
    if (e.h1 != 0) model_fwds++;
    if (e.h2 != 0) model_fwds++;
    if (fl) begin
      holding = 1'b0;
      hold_left = 0;
    end else if (raw) begin
      if (!holding) begin
        holding = 1'b1;
        hold_left = (!load_use && s1 == 1) ? 1 : 0;
      end else if (hold_left > 0) begin
        hold_left--;
      end
    end else begin
      holding = 1'b0;
    end
    mem_slot = ex_slot;
    ex_slot.writes  = adv && writes_reg(op, rd);
    ex_slot.rd      = rd;
    ex_slot.is_load = adv && (op == LOAD);
  endtask

  // Drive one ID cycle (called 2 time units after a posedge).
  task automatic apply_stimulus(input bit v, input bit [6:0] op, input bit [4:0] r1,
                                input bit [4:0] r2, input bit [4:0] rd, input bit fl,
                                output bit stalled);
    exp_t e;
    id_valid = v;
    id_op    = op;
    id_rs1   = r1;
    id_rs2   = r2;
    id_rd    = rd;
    flush    = fl;
    model_step(v, op, r1, r2, rd, fl, e);
    exp_q.push_back(e);
    stalled = e.stall;
    @(posedge clk);
    #2;
    cycle++;
  endtask

  // Present an instruction until it leaves ID (re-presented while stalled).
  task automatic issue(input bit [6:0] op, input bit [4:0] r1, input bit [4:0] r2,
                       input bit [4:0] rd);
    bit st;
    int guard;
    guard = 0;
    do begin
      apply_stimulus(1'b1, op, r1, r2, rd, 1'b0, st);
      guard++;
    end while (st && guard < 6);
  endtask

  task automatic idle(input int n);
    bit st;
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, OPI, 5'd0, 5'd0, 5'd0, 1'b0, st);
  endtask

  // Monitor: samples stall mid-cycle, registered outputs after the edge.
  initial begin
    exp_t e;
    bit   s_stall;
    forever begin
      @(negedge clk);
      s_stall = stall;
      @(posedge clk);
      #1;
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("stall", int'(s_stall), int'(e.stall));
        check_output("hazard_reg1", int'(hazard_reg1), int'(e.h1));
        check_output("hazard_reg2", int'(hazard_reg2), int'(e.h2));
        check_output("is_hazard1", int'(is_hazard1), int'(e.h1 != 0));
        check_output("is_hazard2", int'(is_hazard2), int'(e.h2 != 0));
        check_output("bubble", int'(bubble), int'(e.bub));
      end
    end
  end

  initial begin
    bit [6:0] ops [9];
    bit [6:0] r_op;
    bit [4:0] r_rs1;
    bit [4:0] r_rs2;
    bit [4:0] r_rd;
    bit       r_v;
    bit       r_fl;
    bit       st;
    bit       last_stall;
    int       drain;

    ops = '{LOAD, STORE, BRANCH, JAL, JALR, OPR, OPI, LUI, AUIPC};
    ex_slot  = '{writes: 1'b0, rd: 5'd0, is_load: 1'b0};
    mem_slot = '{writes: 1'b0, rd: 5'd0, is_load: 1'b0};
    holding = 1'b0;
    hold_left = 0;

    #3;
    check_output("rst_stall", int'(stall), 0);
    check_output("rst_bubble", int'(bubble), 0);
    check_output("rst_hazard_reg1", int'(hazard_reg1), 0);
    check_output("rst_hazard_reg2", int'(hazard_reg2), 0);
    check_output("rst_is_hazard1", int'(is_hazard1), 0);
    check_output("rst_is_hazard2", int'(is_hazard2), 0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    mon_en = 1'b1;

    $display("[TB] directed sequences");
    issue(OPI, 5'd1, 5'd0, 5'd5);   // addi x5
    issue(OPR, 5'd5, 5'd7, 5'd6);   // add x6,x5,x7
    idle(2);
    issue(LOAD, 5'd2, 5'd0, 5'd5);  // lw x5
    issue(OPI, 5'd0, 5'd0, 5'd0);   // nop
    issue(OPR, 5'd7, 5'd5, 5'd6);   // add x6,x7,x5
    idle(2);
    issue(LOAD, 5'd2, 5'd0, 5'd5);  // lw x5
    issue(OPR, 5'd5, 5'd1, 5'd6);   // add x6,x5,x1 (load-use)
    idle(2);
    issue(OPR, 5'd1, 5'd2, 5'd5);   // add x5
    issue(OPR, 5'd3, 5'd4, 5'd6);   // add x6
    issue(OPR, 5'd5, 5'd6, 5'd7);   // sub x7,x5,x6
    idle(2);
    issue(OPI, 5'd0, 5'd0, 5'd0);   // addi x0,x0,1
    issue(OPR, 5'd0, 5'd0, 5'd1);   // add x1,x0,x0
    idle(2);
    issue(LOAD, 5'd2, 5'd0, 5'd5);  // lw x5, then flush during the stall
    apply_stimulus(1'b1, OPR, 5'd5, 5'd1, 5'd6, 1'b0, st);
    apply_stimulus(1'b1, OPR, 5'd5, 5'd1, 5'd6, 1'b1, st);
    issue(OPR, 5'd8, 5'd9, 5'd10);
    idle(2);
    issue(OPR, 5'd1, 5'd2, 5'd5);   // add x5
    issue(OPR, 5'd5, 5'd5, 5'd6);   // add x6,x5,x5 (same-stage EX)
    idle(2);
    issue(OPR, 5'd1, 5'd2, 5'd5);   // add x5
    issue(OPI, 5'd0, 5'd0, 5'd0);   // nop
    issue(OPR, 5'd5, 5'd5, 5'd6);   // add x6,x5,x5 (same-stage MEM)
    idle(3);

    $display("[TB] random stream");
    last_stall = 1'b0;
    r_op = OPI; r_rs1 = '0; r_rs2 = '0; r_rd = '0; r_v = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        r_op  = ops[$urandom_range(0, 8)];
        r_rs1 = 5'($urandom_range(0, 7));
        r_rs2 = 5'($urandom_range(0, 7));
        r_rd  = 5'($urandom_range(0, 7));
        r_v   = ($urandom_range(0, 9) != 0);
      end
      r_fl = ($urandom_range(0, 11) == 0);
      apply_stimulus(r_v, r_op, r_rs1, r_rs2, r_rd, r_fl, st);
      last_stall = st;
    end
    idle(3);

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      #2;
      drain++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("[TB] FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("[TB] model stall cycles=%0d forward codes=%0d", model_stalls, model_fwds);

`ifdef HAZARD_STATS_EN
    check_output("stall_cycles", int'(stall_cycles), model_stalls);
    check_output("forward_count", int'(forward_count), model_fwds);
`endif

    // Async reset while the detector is holding a same-stage stall.
    id_valid = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    id_valid = 1'b1; id_op = OPR; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd5;
    @(posedge clk);
    #2;
    id_op = OPR; id_rs1 = 5'd5; id_rs2 = 5'd5; id_rd = 5'd6;
    @(negedge clk);
    check_output("hold_enter_stall", int'(stall), 1);
    @(posedge clk);
    #2;
    check_output("hold_bubble", int'(bubble), 1);
    check_output("hold_stall", int'(stall), 1);
    rst_n = 1'b0;
    #1;
    check_output("async_rst_stall", int'(stall), 0);
    check_output("async_rst_bubble", int'(bubble), 0);
    check_output("async_rst_hazard_reg1", int'(hazard_reg1), 0);
    check_output("async_rst_hazard_reg2", int'(hazard_reg2), 0);
    check_output("async_rst_is_hazard1", int'(is_hazard1), 0);
    check_output("async_rst_is_hazard2", int'(is_hazard2), 0);
    id_valid = 1'b0;
    #10;
    rst_n = 1'b1;
    #10;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
